// File: rtl/apb4_gpio_bridge.sv
// APB4 slave front-end for the GPIO register bank: 2+WAIT_CYCLES cycles per transfer, PREADY low while waits count.
// Optional build macro APB_GPIO_PSLVERR_EN returns PSLVERR on out-of-range words; otherwise the index wraps.
module apb4_gpio_bridge #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned IRQ_SYNC    = 1
) (
  input  logic                                   PCLK,
  input  logic                                   PRESETn,
  input  logic                                   PSEL,
  input  logic                                   PENABLE,
  input  logic                                   PWRITE,
  input  logic [ADDR_W-1:0]                      PADDR,
  input  logic [DATA_W-1:0]                      PWDATA,
  input  logic [DATA_W/8-1:0]                    PSTRB,
  output logic                                   PREADY,
  output logic [DATA_W-1:0]                      PRDATA,
  output logic                                   PSLVERR,
  output logic                                   IRQ,
  output logic                                   reg_we,
  output logic                                   reg_re,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]     reg_addr,
  output logic [DATA_W-1:0]                      reg_wdata,
  output logic [DATA_W/8-1:0]                    reg_wstrb,
  input  logic [DATA_W-1:0]                      reg_rdata,
  input  logic                                   gpio_irq_i
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BYTE_W = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_W - BYTE_W;
  localparam int unsigned MASK_W = $clog2(NUM_REGS);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic             wr_q;
  logic             valid_q;
  logic             setup;
  logic             done;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_mapped;
  logic             idx_valid;
  logic             unused_ok;

  assign idx       = PADDR[ADDR_W-1:BYTE_W];
  assign unused_ok = ^PADDR;

`ifdef APB_GPIO_PSLVERR_EN
  assign idx_mapped = idx;
  assign idx_valid  = (32'(idx) < NUM_REGS);
`else
  // Wrap onto the power-of-two window covering the implemented registers.
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'((64'd1 << MASK_W) - 64'd1);
  assign idx_mapped = idx & IDX_MASK;
  assign idx_valid  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    setup   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          setup   = 1'b1;
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        // Dropping PSEL abandons the transfer silently.
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (PENABLE) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      valid_q   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup) begin
        wr_q      <= PWRITE;
        valid_q   <= idx_valid;
        reg_addr  <= idx_mapped;
        reg_wdata <= PWDATA;
        reg_wstrb <= PWRITE ? PSTRB : '0;
      end
    end
  end

  // Strobes derive from latched request state only, so late bus changes cannot leak through.
  assign PREADY = done;
  assign reg_we = done && valid_q && wr_q;
  assign reg_re = done && valid_q && !wr_q;
  assign PRDATA = reg_re ? reg_rdata : '0;

`ifdef APB_GPIO_PSLVERR_EN
  assign PSLVERR = done && !valid_q;
`else
  assign PSLVERR = 1'b0;
`endif

  generate
    if (IRQ_SYNC != 0) begin : g_irq_sync
      logic [1:0] irq_sync_q;
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          irq_sync_q <= 2'b00;
        end else begin
          irq_sync_q <= {irq_sync_q[0], gpio_irq_i};
        end
      end
      assign IRQ = irq_sync_q[1];
    end else begin : g_irq_pass
      assign IRQ = gpio_irq_i & PRESETn;
    end
  endgenerate

  a_ready_in_access : assert property (@(posedge PCLK) disable iff (!PRESETn)
    PREADY |-> (PSEL && PENABLE));
  a_we_re_exclusive : assert property (@(posedge PCLK) disable iff (!PRESETn)
    !(reg_we && reg_re));

endmodule

// File: tb/tb_apb4_gpio_bridge.sv
// Directed bench for apb4_gpio_bridge: three instances (0, 2 and 3 wait states) behind one shared APB driver.
module tb_apb4_gpio_bridge;

  logic        PCLK;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [5:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        gpio_irq;
  int          sel;

  logic        pready_v [3];
  logic [31:0] prdata_v [3];
  logic        pslverr_v[3];
  logic        irq_v    [3];
  logic        we_v     [3];
  logic        re_v     [3];
  logic [3:0]  raddr_v  [3];
  logic [31:0] rwdata_v [3];
  logic [3:0]  rwstrb_v [3];
  logic [31:0] rdata_v  [3];

  logic [31:0] mem [16];

  int n_chk  = 0;
  int n_fail = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WC = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    apb4_gpio_bridge #(
      .DATA_W(32), .ADDR_W(6), .NUM_REGS(8), .WAIT_CYCLES(WC), .IRQ_SYNC(1)
    ) u_dut (
      .PCLK      (PCLK),
      .PRESETn   (rst_n),
      .PSEL      (psel && (sel == g)),
      .PENABLE   (penable),
      .PWRITE    (pwrite),
      .PADDR     (paddr),
      .PWDATA    (pwdata),
      .PSTRB     (pstrb),
      .PREADY    (pready_v[g]),
      .PRDATA    (prdata_v[g]),
      .PSLVERR   (pslverr_v[g]),
      .IRQ       (irq_v[g]),
      .reg_we    (we_v[g]),
      .reg_re    (re_v[g]),
      .reg_addr  (raddr_v[g]),
      .reg_wdata (rwdata_v[g]),
      .reg_wstrb (rwstrb_v[g]),
      .reg_rdata (rdata_v[g]),
      .gpio_irq_i(gpio_irq)
    );
    assign rdata_v[g] = mem[raddr_v[g]];
  end

  typedef struct {
    int          sel;
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          exp_we;
    bit          exp_re;
    logic [3:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  function automatic int wait_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 2 : 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input int s);
    chk({tag, " PREADY"}, pready_v[s], 0);
    chk({tag, " reg_we"}, we_v[s], 0);
    chk({tag, " reg_re"}, re_v[s], 0);
    chk({tag, " PRDATA"}, prdata_v[s], 0);
    chk({tag, " PSLVERR"}, pslverr_v[s], 0);
  endtask

  task automatic xfer(input vec_t v, input string tag);
    int s;
    s = v.sel;
    @(posedge PCLK); #1;
    sel = s; psel = 1'b1; penable = 1'b0; pwrite = v.wr;
    paddr = v.addr; pwdata = v.wdata; pstrb = v.strb;
    @(negedge PCLK);
    chk_quiet({tag, " setup"}, s);
    @(posedge PCLK); #1;
    // Scramble the bus in the access phase; the request must already be latched.
    penable = 1'b1; paddr = ~v.addr; pwdata = ~v.wdata; pwrite = ~v.wr; pstrb = ~v.strb;
    for (int i = 0; i < wait_of(s); i++) begin
      @(negedge PCLK);
      chk_quiet($sformatf("%s wait%0d", tag, i), s);
      @(posedge PCLK); #1;
    end
    @(negedge PCLK);
    chk({tag, " done PREADY"}, pready_v[s], 1);
    chk({tag, " done reg_we"}, we_v[s], v.exp_we);
    chk({tag, " done reg_re"}, re_v[s], v.exp_re);
    chk({tag, " done PSLVERR"}, pslverr_v[s], v.exp_err);
    chk({tag, " done reg_addr"}, raddr_v[s], v.exp_addr);
    chk({tag, " done reg_wdata"}, rwdata_v[s], v.exp_wdata);
    chk({tag, " done reg_wstrb"}, rwstrb_v[s], v.exp_wstrb);
    chk({tag, " done PRDATA"}, prdata_v[s], v.exp_rdata);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    chk_quiet({tag, " after"}, s);
  endtask

  initial begin
    int nwe;
    int nre;
    logic [6:0] irq_exp;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[1] = 32'h1234_5678;
    mem[3] = 32'hCAFE_0003;
    mem[7] = 32'h7777_0007;

    //            sel wr addr   wdata          strb  we re addr wdata          wstrb rdata          err
    vecs[0] = '{0, 1'b1, 6'h08, 32'hA5A5_0F0F, 4'h3, 1, 0, 4'd2, 32'hA5A5_0F0F, 4'h3, 32'h0,         0};
    vecs[1] = '{2, 1'b0, 6'h04, 32'hFFFF_FFFF, 4'hF, 0, 1, 4'd1, 32'hFFFF_FFFF, 4'h0, 32'h1234_5678, 0};
    vecs[2] = '{0, 1'b1, 6'h0C, 32'h0000_0001, 4'h0, 1, 0, 4'd3, 32'h0000_0001, 4'h0, 32'h0,         0};
    vecs[3] = '{1, 1'b0, 6'h1C, 32'h0000_0000, 4'h5, 0, 1, 4'd7, 32'h0000_0000, 4'h0, 32'h7777_0007, 0};
`ifdef APB_GPIO_PSLVERR_EN
    vecs[4] = '{0, 1'b1, 6'h24, 32'h55AA_55AA, 4'hF, 0, 0, 4'd9, 32'h55AA_55AA, 4'hF, 32'h0,         1};
    vecs[5] = '{2, 1'b0, 6'h3C, 32'h0000_0000, 4'hF, 0, 0, 4'd15, 32'h0000_0000, 4'h0, 32'h0,        1};
`else
    vecs[4] = '{0, 1'b1, 6'h24, 32'h55AA_55AA, 4'hF, 1, 0, 4'd1, 32'h55AA_55AA, 4'hF, 32'h0,         0};
    vecs[5] = '{2, 1'b0, 6'h3C, 32'h0000_0000, 4'hF, 0, 1, 4'd7, 32'h0000_0000, 4'h0, 32'h7777_0007, 0};
`endif
    vecs[6] = '{1, 1'b1, 6'h00, 32'hFEED_BEEF, 4'hC, 1, 0, 4'd0, 32'hFEED_BEEF, 4'hC, 32'h0,         0};
    vecs[7] = '{0, 1'b0, 6'h10, 32'h0000_0000, 4'hF, 0, 1, 4'd4, 32'h0000_0000, 4'h0, 32'hA000_0004, 0};

    rst_n = 1'b0; sel = 0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; gpio_irq = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    for (int g = 0; g < 3; g++) begin
      chk_quiet($sformatf("reset d%0d", g), g);
      chk($sformatf("reset d%0d reg_addr", g), raddr_v[g], 0);
      chk($sformatf("reset d%0d reg_wdata", g), rwdata_v[g], 0);
      chk($sformatf("reset d%0d reg_wstrb", g), rwstrb_v[g], 0);
      chk($sformatf("reset d%0d IRQ", g), irq_v[g], 0);
    end
    @(posedge PCLK); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) xfer(vecs[i], $sformatf("vec%0d", i));

    // Abort: PSEL dropped in the second wait cycle of the two-wait instance.
    @(posedge PCLK); #1;
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 6'h04; pstrb = 4'hF;
    @(negedge PCLK);
    chk_quiet("abort setup", 1);
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    chk_quiet("abort wait0", 1);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk_quiet($sformatf("abort idle%0d", i), 1);
    end
    xfer('{1, 1'b1, 6'h14, 32'h0BAD_F00D, 4'h9, 1, 0, 4'd5, 32'h0BAD_F00D, 4'h9, 32'h0, 0},
         "post-abort");

    // Reset asserted in the completion cycle of the zero-wait instance.
    @(posedge PCLK); #1;
    sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h18;
    pwdata = 32'h1357_9BDF; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    chk("rst-mid PREADY before", pready_v[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("rst-mid async", 0);
    chk("rst-mid async reg_addr", raddr_v[0], 0);
    chk("rst-mid async reg_wdata", rwdata_v[0], 0);
    chk("rst-mid async reg_wstrb", rwstrb_v[0], 0);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    rst_n = 1'b1;
    xfer('{0, 1'b1, 6'h18, 32'h2468_ACE0, 4'h6, 1, 0, 4'd6, 32'h2468_ACE0, 4'h6, 32'h0, 0},
         "post-reset");

    // Back-to-back write then read of word 3: four cycles, one pulse each.
    nwe = 0; nre = 0;
    @(posedge PCLK); #1;
    sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h0C;
    pwdata = 32'h0F0F_0F0F; pstrb = 4'hF;
    @(negedge PCLK);
    chk("b2b c1 PREADY", pready_v[0], 0);
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    chk("b2b c2 PREADY", pready_v[0], 1);
    chk("b2b c2 reg_we", we_v[0], 1);
    nwe += int'(we_v[0]); nre += int'(re_v[0]);
    @(posedge PCLK); #1;
    penable = 1'b0; pwrite = 1'b0;
    @(negedge PCLK);
    chk("b2b c3 PREADY", pready_v[0], 0);
    nwe += int'(we_v[0]); nre += int'(re_v[0]);
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    chk("b2b c4 PREADY", pready_v[0], 1);
    chk("b2b c4 reg_re", re_v[0], 1);
    chk("b2b c4 PRDATA", prdata_v[0], 32'hCAFE_0003);
    chk("b2b c4 reg_addr", raddr_v[0], 3);
    chk("b2b c4 reg_wstrb", rwstrb_v[0], 0);
    nwe += int'(we_v[0]); nre += int'(re_v[0]);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    nwe += int'(we_v[0]); nre += int'(re_v[0]);
    chk("b2b reg_we count", 64'(nwe), 1);
    chk("b2b reg_re count", 64'(nre), 1);

    // Three-cycle interrupt pulse through the two-flop synchroniser.
    irq_exp = 7'b0011100;
    @(posedge PCLK); #1;
    for (int c = 0; c < 7; c++) begin
      gpio_irq = (c < 3);
      @(negedge PCLK);
      chk($sformatf("irq cycle%0d", c), irq_v[0], irq_exp[6-c]);
      @(posedge PCLK); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb4_gpio_bridge.md
# apb4_gpio_bridge

Parametrised APB4 slave front-end for the GPIO register bank. It supersedes the fixed 4-bit/32-bit GPIO APB interface with configurable data, address and register count, programmable wait states, byte strobes, latched back-end request signals and address-range error response. It sits between the APB interconnect and the GPIO core. All back-end strobes are single-cycle pulses issued only on the completing APB access cycle.

## Interface
Parameters:
- DATA_W, 32, data width; multiple of 8, range 8..64
- ADDR_W, 6, PADDR width in bytes; must be at least log2(DATA_W/8)+1
- NUM_REGS, 8, number of implemented word registers; word index is PADDR[ADDR_W-1:log2(DATA_W/8)]
- WAIT_CYCLES, 0, extra access-phase cycles with PREADY low; range 0..15
- IRQ_SYNC, 1, 1 = 2-flop synchroniser on gpio_irq_i; 0 = pass-through

Ports:
- PCLK  in  1  single clock for the block; rising edge
- PRESETn  in  1  asynchronous, active-low reset
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write
- PADDR  in  ADDR_W  byte address
- PWDATA  in  DATA_W  write data
- PSTRB  in  DATA_W/8  write byte strobes
- PREADY  out  1  transfer complete
- PRDATA  out  DATA_W  read data
- PSLVERR  out  1  error response, valid with PREADY
- IRQ  out  1  interrupt to system
- reg_we  out  1  write pulse
- reg_re  out  1  read pulse
- reg_addr  out  ADDR_W-log2(DATA_W/8)  word index, latched
- reg_wdata  out  DATA_W  latched PWDATA
- reg_wstrb  out  DATA_W/8  latched PSTRB; all zero for reads
- reg_rdata  in  DATA_W  combinational read data for reg_addr
- gpio_irq_i  in  1  GPIO core interrupt

## Operation
- FSM states: IDLE, ACCESS. Reset state is IDLE.
- IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup phase). On this edge the block latches PADDR, PWRITE, PWDATA and PSTRB, loads wait counter = WAIT_CYCLES, and computes valid = (word index < NUM_REGS).
- ACCESS:
  - While counter != 0: PREADY=0 and counter decrements each cycle.
  - When counter == 0 and PSEL=1 and PENABLE=1: PREADY=1. This cycle is the completion cycle, and the FSM returns to IDLE on the next edge.
  - PSEL=0 in ACCESS aborts: return to IDLE; no strobe; no response.
- Completion cycle behaviour:
  - Valid write: reg_we=1.
  - Valid read: reg_re=1 and PRDATA=reg_rdata.
  - Otherwise PRDATA=0.
  - Back-end outputs use only latched values. PADDR, PWRITE and PWDATA changes during ACCESS are ignored.
- Reads force reg_wstrb=0 regardless of PSTRB.
- Write with PSTRB=0 still pulses reg_we; the back end applies no bytes.
- Back-to-back transfers: a setup phase in the cycle after completion is accepted normally.
- IRQ: gpio_irq_i through 2 flops when IRQ_SYNC=1, else direct.

## Timing
- Reset values: PREADY 0, PRDATA 0, PSLVERR 0, reg_we 0, reg_re 0, reg_addr 0, reg_wdata 0, reg_wstrb 0, IRQ 0. Synchroniser flops clear to 0.
- Transfer length is 2+WAIT_CYCLES cycles from setup to completion, inclusive.
- PREADY, reg_we, reg_re and PSLVERR are each high for exactly one cycle per completed transfer, and only in the completion cycle.
- PRDATA is combinational from reg_rdata in the completion cycle. It is 0 in every other cycle.
- IRQ latency is 2 cycles when IRQ_SYNC=1, 0 otherwise.
- Reset asserted mid-transfer: all outputs go to reset values immediately, the FSM goes to IDLE, and no strobe is issued.

## Configuration
- APB_GPIO_PSLVERR_EN defined:
  - An invalid address completes normally with PREADY=1, PSLVERR=1 and PRDATA=0.
  - reg_we and reg_re are suppressed for that transfer.
- APB_GPIO_PSLVERR_EN undefined:
  - PSLVERR is tied 0.
  - Word index is taken modulo NUM_REGS, rounded to a power of two: reg_addr = index & (2^ceil(log2 NUM_REGS) - 1). Every access is treated as valid; invalid in-range slots read reg_rdata as driven by the back end.

## Test plan
- Zero-wait write, DATA_W=32, WAIT_CYCLES=0: PADDR=0x08, PWDATA=0xA5A5_0F0F, PSTRB=4'b0011 -> PREADY high on cycle 2; reg_we pulse with reg_addr=2, reg_wdata=0xA5A5_0F0F, reg_wstrb=4'b0011.
- Wait-state read, WAIT_CYCLES=3, reg_rdata=0x1234_5678 at PADDR=0x04 -> PREADY low for 3 access cycles, then high for 1 cycle with PRDATA=0x1234_5678 and reg_re pulse; PRDATA=0 otherwise.
- Out-of-range access, NUM_REGS=8, PADDR=0x24, write:
  - With APB_GPIO_PSLVERR_EN: PSLVERR=1 with PREADY and no reg_we.
  - Without it: reg_we pulse with reg_addr=1.
- Abort and reset: drop PSEL in the second wait cycle (WAIT_CYCLES=2) -> no PREADY, no strobe, FSM back to IDLE. Assert PRESETn=0 mid-access -> all outputs 0 asynchronously; the next transfer completes normally.
- Back-to-back and IRQ:
  - Write then immediate read to same register -> both complete in 4 cycles total, one reg_we then one reg_re.
  - gpio_irq_i pulse of 3 cycles -> IRQ high 3 cycles, delayed 2 cycles when IRQ_SYNC=1.
